// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one memory port between instruction fetch and load/store.
// One transaction is in flight at a time: IDLE accepts, REQ issues it, WAIT collects the response.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,

  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  state_t              state;
  owner_t              owner;
  owner_t              last_grant;
  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_wen;
  logic [DATA_W-1:0]   lat_wdata;
  logic [MASK_W-1:0]   lat_wmask;

  logic grant_ls;
  logic grant_if;
  logic in_req;
  logic resp_fire;

  // On a tie the requester that did not win last time gets the port.
  assign grant_ls = ls_req_valid && (!if_req_valid || last_grant == OWN_IF);
  assign grant_if = if_req_valid && !grant_ls;

  // Ready is masked by rst so no handshake is ever reported on a cycle the FSM discards.
  assign if_req_ready = (state == IDLE) && !rst && grant_if;
  assign ls_req_ready = (state == IDLE) && !rst && grant_ls;

  assign in_req        = (state == REQ) && !rst;
  assign mem_req_valid = in_req;
  assign mem_addr      = in_req ? lat_addr  : '0;
  assign mem_wen       = in_req ? lat_wen   : 1'b0;
  assign mem_wdata     = in_req ? lat_wdata : '0;
  assign mem_wmask     = in_req ? lat_wmask : '0;

  // Responses outside WAIT are stray and must never reach a requester.
  assign resp_fire     = (state == WAIT) && !rst && mem_resp_valid;
  assign if_resp_valid = resp_fire && (owner == OWN_IF);
  assign ls_resp_valid = resp_fire && (owner == OWN_LS);
  assign if_rdata      = if_resp_valid ? mem_rdata : '0;
  assign ls_rdata      = ls_resp_valid ? mem_rdata : '0;

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_grant <= OWN_IF;
      lat_addr   <= '0;
      lat_wen    <= 1'b0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req_ready) begin
            state      <= REQ;
            owner      <= OWN_IF;
            last_grant <= OWN_IF;
            lat_addr   <= if_addr;
            lat_wen    <= 1'b0;
            lat_wdata  <= '0;
            lat_wmask  <= '0;
          end else if (ls_req_ready) begin
            state      <= REQ;
            owner      <= OWN_LS;
            last_grant <= OWN_LS;
            lat_addr   <= ls_addr;
            lat_wen    <= ls_wen;
            lat_wdata  <= ls_wdata;
            lat_wmask  <= ls_wmask;
          end
        end
        REQ: begin
          if (mem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (mem_resp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of grant order and memory-port behaviour.
module tb_mem_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int MASK_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_valid, if_req_ready, if_resp_valid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata, ls_rdata;
  logic [MASK_W-1:0] ls_wmask;
  logic              mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: who won the previous arbitration (1 = IF, so LS wins the first tie).
  bit last_was_if;
  string grant_log;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " mem_req_valid"}, mem_req_valid, 0);
    check({tag, " mem_addr"}, mem_addr, 0);
    check({tag, " mem_wdata"}, mem_wdata, 0);
    check({tag, " mem_wmask"}, mem_wmask, 0);
    check({tag, " if_resp_valid"}, if_resp_valid, 0);
    check({tag, " ls_resp_valid"}, ls_resp_valid, 0);
    check({tag, " if_rdata"}, if_rdata, 0);
    check({tag, " ls_rdata"}, ls_rdata, 0);
  endtask

  // One full transaction starting in IDLE. Expected winner, memory fields and response
  // routing are derived from the arbitration rule and the requester's own fields.
  task automatic do_txn(input bit ifv, input bit lsv,
                        input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] la,
                        input bit wen, input logic [DATA_W-1:0] wd, input logic [MASK_W-1:0] wm,
                        input int ready_delay, input int resp_delay,
                        input logic [DATA_W-1:0] rd, input bit keep_valid);
    bit win_ls;
    logic [ADDR_W-1:0] exp_addr;
    win_ls = lsv && (!ifv || last_was_if);
    exp_addr = win_ls ? la : ia;

    if_req_valid = ifv; ls_req_valid = lsv;
    if_addr = ia; ls_addr = la; ls_wen = wen; ls_wdata = wd; ls_wmask = wm;
    #1;
    check("accept if_ready", if_req_ready, !win_ls);
    check("accept ls_ready", ls_req_ready, win_ls);
    check("accept busy", busy, 0);
    tick();
    last_was_if = !win_ls;
    grant_log = {grant_log, win_ls ? "LS " : "IF "};
    if (!keep_valid) begin
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
    end
    // The requester fields may change freely once accepted.
    ls_addr = ~la; if_addr = ~ia; ls_wdata = ~wd;
    #1;
    check("req mem_req_valid", mem_req_valid, 1);
    check("req mem_addr", mem_addr, exp_addr);
    check("req mem_wen", mem_wen, win_ls ? wen : 1'b0);
    check("req mem_wdata", mem_wdata, win_ls ? wd : '0);
    check("req mem_wmask", mem_wmask, win_ls ? wm : '0);
    check("req no accept", {if_req_ready, ls_req_ready}, 0);
    for (int i = 0; i < ready_delay; i++) begin
      mem_resp_valid = 1'b1; mem_rdata = rd ^ 64'h5555;
      tick();
      check("stall mem_req_valid", mem_req_valid, 1);
      check("stall mem_addr", mem_addr, exp_addr);
      check("stall no accept", {if_req_ready, ls_req_ready}, 0);
      check("stall stray resp", {if_resp_valid, ls_resp_valid}, 0);
    end
    mem_resp_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    check("wait mem_req_valid", mem_req_valid, 0);
    check("wait mem_addr", mem_addr, 0);
    check("wait busy", busy, 1);
    for (int i = 0; i < resp_delay; i++) begin
      tick();
      check("wait no resp", {if_resp_valid, ls_resp_valid}, 0);
      check("wait no accept", {if_req_ready, ls_req_ready}, 0);
    end
    mem_resp_valid = 1'b1; mem_rdata = rd;
    #1;
    check("resp if_valid", if_resp_valid, !win_ls);
    check("resp ls_valid", ls_resp_valid, win_ls);
    check("resp if_rdata", if_rdata, win_ls ? '0 : rd);
    check("resp ls_rdata", ls_rdata, win_ls ? rd : '0);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    check("done busy", busy, 0);
    check("done resp pulse", {if_resp_valid, ls_resp_valid}, 0);
  endtask

  initial begin
    rst = 1'b1;
    if_req_valid = 0; if_addr = '0;
    ls_req_valid = 0; ls_addr = '0; ls_wen = 0; ls_wdata = '0; ls_wmask = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    grant_log = "";

    // Reset state.
    tick(); tick();
    check_idle_outputs("reset");
    check("reset if_ready", if_req_ready, 0);
    check("reset ls_ready", ls_req_ready, 0);
    rst = 1'b0;
    last_was_if = 1'b1;
    #1;
    check_idle_outputs("post-reset");

    // Stray response in IDLE.
    mem_resp_valid = 1'b1; mem_rdata = 64'hcafe_f00d;
    #1;
    check_idle_outputs("stray idle");
    tick();
    mem_resp_valid = 1'b0;
    check("stray idle busy after", busy, 0);

    // First tie goes to LS; IF follows once LS completes.
    do_txn(1, 1, 64'h8000_0000, 64'h8000_1000, 0, '0, 8'h00, 0, 0, 64'h0123_4567_89ab_cdef, 1);
    do_txn(1, 1, 64'h8000_0000, 64'h8000_1000, 0, '0, 8'h00, 0, 0, 64'hfeed_face_0000_1111, 0);

    // LS store with minimum latency.
    do_txn(0, 1, '0, 64'h8000_0008, 1, 64'h1122_3344_5566_7788, 8'hff, 0, 0, 64'h0, 0);

    // IF read with three stalled cycles on the memory port.
    do_txn(1, 0, 64'h8000_0040, '0, 0, '0, 8'h00, 3, 1, 64'haaaa_bbbb_cccc_dddd, 0);

    // Six back-to-back ties must alternate, starting with LS after the IF above.
    grant_log = "";
    for (int i = 0; i < 6; i++)
      do_txn(1, 1, 64'h1000 + 64'(i * 8), 64'h2000 + 64'(i * 8), 1'(i % 2), 64'(i) * 64'h0101,
             8'h0f, 0, 0, 64'(i) + 64'h77, 1);
    n_checks++;
    assert (grant_log == "LS IF LS IF LS IF ") else begin
      n_errors++;
      $error("FAIL alternation: observed '%s' expected 'LS IF LS IF LS IF '", grant_log);
    end
    if_req_valid = 0; ls_req_valid = 0;

    // A requester withdrawing without a handshake leaves nothing behind.
    tick();
    if_req_valid = 1'b1;
    #1;
    check("withdraw ready seen", if_req_ready, 1);
    if_req_valid = 1'b0;
    #1;
    check("withdraw ready gone", if_req_ready, 0);
    tick();
    check("withdraw busy", busy, 0);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      bit ifv, lsv;
      int sel;
      logic [MASK_W-1:0] wm;
      sel = $urandom_range(0, 2);
      ifv = (sel != 1); lsv = (sel != 0);
      case ($urandom_range(0, 3))
        0: wm = 8'h01;
        1: wm = 8'h03;
        2: wm = 8'h0f;
        default: wm = 8'hff;
      endcase
      do_txn(ifv, lsv, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), {$urandom, $urandom},
             wm, $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom}, 1'($urandom));
    end
    if_req_valid = 0; ls_req_valid = 0;
    tick();

    // Reset in WAIT abandons the transaction; a late response is dropped.
    ls_req_valid = 1'b1; ls_addr = 64'h8000_0100; ls_wen = 0;
    tick();
    ls_req_valid = 1'b0;
    check("rst-wait in REQ", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("rst-wait in WAIT", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_was_if = 1'b1;
    mem_resp_valid = 1'b1; mem_rdata = 64'hdead_beef;
    #1;
    check_idle_outputs("rst-wait late resp");
    tick();
    mem_resp_valid = 1'b0;
    check("rst-wait busy after", busy, 0);

    // Grant history is back to reset: a tie goes to LS again.
    do_txn(1, 1, 64'h3000, 64'h4000, 0, '0, 8'h00, 0, 0, 64'h99, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 64, request address width.
REQ-002 Parameter: DATA_W, default 64, data width; mask width SHALL be DATA_W/8.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 if_req_valid  input  1  instruction-fetch read request.
REQ-006 if_req_ready  output  1  fetch request accepted this cycle.
REQ-007 if_addr  input  ADDR_W  fetch address.
REQ-008 if_resp_valid  output  1  fetch read data valid, one-cycle pulse.
REQ-009 if_rdata  output  DATA_W  fetch read data.
REQ-010 ls_req_valid  input  1  load/store request.
REQ-011 ls_req_ready  output  1  load/store request accepted this cycle.
REQ-012 ls_addr  input  ADDR_W  load/store address.
REQ-013 ls_wen  input  1  1 = write, 0 = read.
REQ-014 ls_wdata  input  DATA_W  store data.
REQ-015 ls_wmask  input  DATA_W/8  store byte mask (01/03/0f/ff by width).
REQ-016 ls_resp_valid  output  1  load/store completion pulse; for writes, ack only.
REQ-017 ls_rdata  output  DATA_W  load raw 64-bit data; lane extraction is done downstream.
REQ-018 mem_req_valid  output  1  request to the shared memory port.
REQ-019 mem_req_ready  input  1  memory port accepts the request.
REQ-020 mem_addr, mem_wen, mem_wdata, mem_wmask  output  ADDR_W/1/DATA_W/DATA_W/8  latched request fields.
REQ-021 mem_resp_valid  input  1  memory response valid.
REQ-022 mem_rdata  input  DATA_W  memory read data.
REQ-023 busy  output  1  high whenever state is not IDLE.

Function
REQ-024 FSM states SHALL be IDLE, REQ and WAIT; exactly one transaction is outstanding at a time.
REQ-025 In IDLE, grant: only one valid -> that requester; both valid -> the requester not in last_grant (round-robin).
REQ-026 if_req_ready/ls_req_ready SHALL be high only in IDLE, only for the granted requester, and combinationally from the valids; never both high.
REQ-027 On an accept handshake, the block SHALL latch addr/wen/wdata/wmask and owner, update last_grant, and go to REQ next cycle; if_* requests latch wen=0, wmask=0, wdata=0.
REQ-028 In REQ, mem_req_valid=1 with the latched fields held stable; on mem_req_ready=1 the FSM SHALL go to WAIT next cycle.
REQ-029 In WAIT, on mem_resp_valid=1 the owner's resp_valid SHALL be 1 in that same cycle with rdata=mem_rdata (combinational pass-through), and the FSM SHALL go to IDLE next cycle.
REQ-030 Minimum latency: accept in cycle N -> mem_req_valid in N+1 -> response earliest in N+2 -> next accept earliest in N+3.
REQ-031 mem_resp_valid in IDLE or REQ SHALL be ignored; no resp_valid pulse is produced.
REQ-032 The non-owner resp_valid SHALL stay 0; each rdata output SHALL read 0 when its resp_valid is 0.
REQ-033 A requester dropping req_valid without a handshake SHALL have no effect.
REQ-034 mem_* outputs SHALL be 0 outside REQ, except mem_req_valid, which is 0 by definition.

Reset
REQ-035 While rst=1 at posedge clk: state=IDLE, last_grant=IF (LSU wins the first tie), latched fields=0.
REQ-036 During and after reset, all outputs SHALL be 0 until a new request is presented.
REQ-037 Reset mid-transaction (REQ or WAIT) SHALL abandon it; a later mem_resp_valid SHALL be ignored.

Verification
REQ-038 Reset, then both valid, if_addr=0x80000000, ls_addr=0x80001000 -> ls granted first; if granted after ls completes.
REQ-039 LS store ls_addr=0x80000008, wdata=0x1122334455667788, wmask=0xff, mem_req_ready=1, resp the next cycle -> mem_* fields match, ls_resp_valid pulses 1 cycle, if_resp_valid stays 0.
REQ-040 IF read, mem_req_ready held 0 for 3 cycles -> mem_req_valid held 4 cycles with a stable mem_addr; no new accept during this time.
REQ-041 Both requesters continuously valid for 6 transactions -> grants alternate LS, IF, LS, IF, LS, IF.
REQ-042 rst asserted in WAIT, then mem_resp_valid=1 with mem_rdata=0xdeadbeef -> no resp_valid pulse; state IDLE; busy=0.
REQ-043 Stray mem_resp_valid in IDLE -> both resp_valid outputs stay 0.
